// File: rtl/issue_queue_mdu_param_pkg.sv
// Shared types for the multiply/divide issue queue.
// Supplies PREG_W, the wake tag type, UOPBundle and iq_mdu_entry_t.
package issue_queue_mdu_param_pkg;

    localparam int PREG_W = 6;

    typedef logic [PREG_W-1:0] preg_t;

    typedef struct packed {
        logic [7:0] id;
        preg_t      pdst;
        preg_t      prs1;
        preg_t      prs2;
        logic       isMul;
    } UOPBundle;

    typedef struct packed {
        UOPBundle uop;
        logic     prs1_rdy;
        logic     prs2_rdy;
    } iq_mdu_entry_t;

endpackage

// File: rtl/issue_queue_mdu_param_entry.sv
// One issue queue slot: state, wakeup compare, shift/enqueue mux.
// Ports: clk, rst (async low), flush, shift_i/up_*_i from the slot above,
//   enq_we_i/enq_data_i, wake_valid_i/wake_paddr_i, valid_o/data_o.
module iq_mdu_param_entry
    import issue_queue_mdu_param_pkg::*;
#(
    parameter int WAKE_W = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             flush,
    input  logic                             shift_i,
    input  logic                             up_valid_i,
    input  iq_mdu_entry_t                    up_data_i,
    input  logic                             enq_we_i,
    input  iq_mdu_entry_t                    enq_data_i,
    input  logic [WAKE_W-1:0]                wake_valid_i,
    input  logic [WAKE_W-1:0][PREG_W-1:0]    wake_paddr_i,
    output logic                             valid_o,
    output iq_mdu_entry_t                    data_o
);

    logic          valid_q, valid_d;
    iq_mdu_entry_t data_q, data_d;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (shift_i) begin
            valid_d = up_valid_i;
            data_d  = up_data_i;
        end
        if (enq_we_i) begin
            valid_d = 1'b1;
            data_d  = enq_data_i;
        end
        // Wakeup is applied after the mux so fresh enqueues catch it too.
        for (int k = 0; k < WAKE_W; k++) begin
            if (wake_valid_i[k]) begin
                if (wake_paddr_i[k] == data_d.uop.prs1)
                    data_d.prs1_rdy = 1'b1;
                if (wake_paddr_i[k] == data_d.uop.prs2)
                    data_d.prs2_rdy = 1'b1;
            end
        end
        if (flush)
            valid_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/issue_queue_mdu_param.sv
// Age-ordered collapsing issue queue feeding the multiplier and divider.
// Ports: clk, rst (async low), flush, enq_valid/enq_data/enq_ready,
//   wake_valid/wake_paddr, mul_busy/div_busy, issue_valid/issue_data, count.
// Macro MDU_BUSY_MASK_EN: busy signals block only their own unit's uops.
module issue_queue_mdu_param
    import issue_queue_mdu_param_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int ENQ_W  = 2,
    parameter int WAKE_W = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              flush,
    input  logic [ENQ_W-1:0]                  enq_valid,
    input  iq_mdu_entry_t [ENQ_W-1:0]         enq_data,
    output logic                              enq_ready,
    input  logic [WAKE_W-1:0]                 wake_valid,
    input  logic [WAKE_W-1:0][PREG_W-1:0]     wake_paddr,
    input  logic                              mul_busy,
    input  logic                              div_busy,
    output logic                              issue_valid,
    output UOPBundle                          issue_data,
    output logic [$clog2(DEPTH+1)-1:0]        count
);

    localparam int CW = $clog2(DEPTH+1);
    localparam int SW = $clog2(DEPTH);

    logic [CW-1:0]  count_q, count_d;
    logic [DEPTH-1:0] v;
    iq_mdu_entry_t  e [DEPTH];
    logic [DEPTH-1:0] elig;
    logic [DEPTH-1:0] shift;
    logic [DEPTH-1:0] enq_we;
    iq_mdu_entry_t  enq_d [DEPTH];
    logic [SW-1:0]  sel;
    logic           found;
    logic           accept;
    int             n_acc;

    always_comb begin
        elig = '0;
        for (int i = 0; i < DEPTH; i++) begin
            logic ok;
`ifdef MDU_BUSY_MASK_EN
            ok = e[i].uop.isMul ? !mul_busy : !div_busy;
`else
            ok = !(mul_busy || div_busy);
`endif
            elig[i] = v[i] && e[i].prs1_rdy && e[i].prs2_rdy && ok;
        end
    end

    // Descending scan leaves the oldest eligible slot selected.
    always_comb begin
        found = 1'b0;
        sel   = '0;
        for (int i = DEPTH-1; i >= 0; i--) begin
            if (elig[i]) begin
                found = 1'b1;
                sel   = SW'(i);
            end
        end
    end

    assign issue_valid = found && !flush;
    assign issue_data  = issue_valid ? e[sel].uop : '0;

    assign enq_ready = (DEPTH - int'(count_q)) >= ENQ_W;
    assign accept    = enq_ready && !flush;

    always_comb begin
        n_acc = 0;
        for (int p = 0; p < ENQ_W; p++)
            if (accept && enq_valid[p])
                n_acc = n_acc + 1;
    end

    // Valid ports are packed in order starting at count - issued.
    always_comb begin
        int r;
        int n;
        r = int'(count_q) - int'(issue_valid);
        for (int j = 0; j < DEPTH; j++) begin
            shift[j]  = issue_valid && (j >= int'(sel));
            enq_we[j] = 1'b0;
            enq_d[j]  = '0;
            n = 0;
            for (int p = 0; p < ENQ_W; p++) begin
                if (accept && enq_valid[p]) begin
                    if (r + n == j) begin
                        enq_we[j] = 1'b1;
                        enq_d[j]  = enq_data[p];
                    end
                    n = n + 1;
                end
            end
        end
    end

    always_comb begin
        if (flush)
            count_d = '0;
        else
            count_d = CW'(int'(count_q) + n_acc - int'(issue_valid));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            count_q <= '0;
        else
            count_q <= count_d;
    end

    assign count = count_q;

    for (genvar j = 0; j < DEPTH; j++) begin : g_slot
        logic          up_v;
        iq_mdu_entry_t up_e;
        if (j < DEPTH-1) begin : g_up
            assign up_v = v[j+1];
            assign up_e = e[j+1];
        end else begin : g_top
            assign up_v = 1'b0;
            assign up_e = '0;
        end
        iq_mdu_param_entry #(
            .WAKE_W(WAKE_W)
        ) u_entry (
            .clk         (clk),
            .rst         (rst),
            .flush       (flush),
            .shift_i     (shift[j]),
            .up_valid_i  (up_v),
            .up_data_i   (up_e),
            .enq_we_i    (enq_we[j]),
            .enq_data_i  (enq_d[j]),
            .wake_valid_i(wake_valid),
            .wake_paddr_i(wake_paddr),
            .valid_o     (v[j]),
            .data_o      (e[j])
        );
    end

endmodule

// File: doc/issue_queue_mdu_param.md
ISSUE_QUEUE_MDU_PARAM -- requirements
Module: issue_queue_mdu_param

Interface
REQ-001 SHALL have parameter DEPTH, default 8, meaning queue entries (2..16).
REQ-002 SHALL have parameter ENQ_W, default 2, meaning enqueue ports per cycle (1..2).
REQ-003 SHALL have parameter WAKE_W, default 4, meaning wakeup broadcast ports.
REQ-004 SHALL have port clk  in  1  meaning single clock, rising edge.
REQ-005 SHALL have port rst  in  1  meaning asynchronous, active-low reset.
REQ-006 SHALL have port flush  in  1  meaning synchronous pipeline flush.
REQ-007 SHALL have port enq_valid  in  ENQ_W  meaning per-port enqueue request.
REQ-008 SHALL have port enq_data  in  ENQ_W x iq_mdu_entry_t  meaning uop, prs1/prs2 tags and ready bits, isMul.
REQ-009 SHALL have port enq_ready  out  1  meaning free slots >= ENQ_W, from registered count.
REQ-010 SHALL have port wake_valid  in  WAKE_W  meaning wakeup enables.
REQ-011 SHALL have port wake_paddr  in  WAKE_W x PREG_W  meaning woken physical register tags.
REQ-012 SHALL have port mul_busy  in  1  meaning multiplier cannot accept.
REQ-013 SHALL have port div_busy  in  1  meaning divider cannot accept.
REQ-014 SHALL have port issue_valid  out  1  meaning issue_data is issued this cycle.
REQ-015 SHALL have port issue_data  out  UOPBundle  meaning selected uop.
REQ-016 SHALL have port count  out  $clog2(DEPTH+1)  meaning occupied entries.

Function
REQ-017 SHALL keep entries age-ordered and collapsing, oldest at index 0, valid entries contiguous from 0.
REQ-018 SHALL select combinationally the lowest-index valid entry with prs1_rdy && prs2_rdy && its unit eligible (REQ-028); issue_valid is 0 if no entry qualifies or flush=1.
REQ-019 SHALL remove the issued entry at the clock edge and shift every higher entry down by one.
REQ-020 SHALL write accepted enqueues at index count - issued, port 0 before port 1; an invalid port 0 with a valid port 1 places port 1 at that index.
REQ-021 SHALL ignore all enqueues when enq_ready=0; no partial acceptance.
REQ-022 SHALL set a ready bit when any wake_valid[k] tag matches it, applied to next-state data, including entries enqueued that cycle.
REQ-023 SHALL not allow an entry enqueued or woken in cycle N to issue before cycle N+1.
REQ-024 SHALL update count to count + accepted - issued each cycle, never exceeding DEPTH.
REQ-025 SHALL, on flush, invalidate all entries and set count=0 next cycle, dropping same-cycle enqueues.

Reset
REQ-026 SHALL, while rst=0, hold all entries invalid, count=0, enq_ready=1, issue_valid=0, issue_data=0.
REQ-027 SHALL take effect immediately mid-operation, including in a cycle with an enqueue and an issue, with no entry surviving.

Configuration
REQ-028 SHALL honour macro MDU_BUSY_MASK_EN: when defined, isMul entries are ineligible only while mul_busy and divide entries only while div_busy, so a younger ready entry may bypass; when undefined, no entry is eligible while mul_busy || div_busy.

Structure
REQ-029 SHALL take iq_mdu_entry_t, UOPBundle, PREG_W and wake-tag types from the shared defines package.
REQ-030 SHALL use one sub-module iq_mdu_param_entry per slot holding state, wake compare and shift/enqueue muxing; selection and count live in the top.

Verification
REQ-031 SHALL show: reset, enqueue 2 ready uops (mul, div) -> count=2 next cycle, mul issues cycle+1, div issues cycle+2.
REQ-032 SHALL show: DEPTH=8, fill to 7 -> enq_ready=0; enqueue attempt ignored; after one issue count=6, enq_ready=1.
REQ-033 SHALL show: enqueue uop with prs1=0x21 not ready, wake_paddr[3]=0x21 same cycle -> issues next cycle.
REQ-034 SHALL show: head div, entry 1 mul, div_busy=1 -> with MDU_BUSY_MASK_EN the mul issues first; without it nothing issues.
REQ-035 SHALL show: count=5, flush together with 2 enqueues -> count=0, issue_valid=0 next cycle.
REQ-036 SHALL show: rst asserted while an issue and an enqueue occur -> all outputs at reset values without waiting for clk.
